// File: rtl/fmap_stream_reader_if.sv
// Handshake bundle for fmap_stream_reader.
//   fmap_in/fmap_valid/fmap_ready : parallel frame capture from the conv stage
//   px_data/px_row/px_col/px_last : current streamed element and its tags
//   px_valid/px_ready             : element handshake toward the serial consumer
//   frame_max/frame_done          : per-frame max and completion pulse
// slave  : the reader itself
// master : the environment (frame producer + element consumer)
interface fmap_stream_reader_if #(
    parameter int ROWS = 14,
    parameter int COLS = 14,
    parameter int EW   = 4,
    parameter int RW   = 4
);
    logic [ROWS*COLS*EW-1:0] fmap_in;
    logic                    fmap_valid;
    logic                    fmap_ready;
    logic [EW-1:0]           px_data;
    logic [RW-1:0]           px_row;
    logic [RW-1:0]           px_col;
    logic                    px_last;
    logic                    px_valid;
    logic                    px_ready;
    logic [EW-1:0]           frame_max;
    logic                    frame_done;

    modport slave (
        input  fmap_in, fmap_valid, px_ready,
        output fmap_ready, px_data, px_row, px_col, px_last, px_valid,
               frame_max, frame_done
    );

    modport master (
        output fmap_in, fmap_valid, px_ready,
        input  fmap_ready, px_data, px_row, px_col, px_last, px_valid,
               frame_max, frame_done
    );
endinterface

// File: rtl/fmap_stream_reader.sv
// Captures a complete ROWSxCOLS feature map in one cycle and streams it out
// one element per px handshake in row-major order, with row/col tags, a last
// flag, a one-cycle frame_done pulse and the frame's maximum element.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : fmap_stream_reader_if.slave (capture side + element stream side)
// Module parameters must match the parameters of the connected interface.
module fmap_stream_reader #(
    parameter int ROWS = 14,
    parameter int COLS = 14,
    parameter int EW   = 4,
    parameter int RW   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    fmap_stream_reader_if.slave     bus
);
    localparam int N  = ROWS * COLS;
    localparam int IW = $clog2(N + 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t          state;
    logic [N*EW-1:0] shadow;
    logic [IW-1:0]   idx;
    logic [EW-1:0]   run_max;

    logic            hs;
    logic            col_wrap;
    logic [RW-1:0]   nxt_row;
    logic [RW-1:0]   nxt_col;
    logic [IW-1:0]   nxt_idx;
    logic [EW-1:0]   nxt_data;
    logic [EW-1:0]   max_cur;

    // Linear element index is tracked alongside row/col so the next element
    // can be registered into px_data without a row*COLS multiply.
    always_comb begin
        hs       = bus.px_valid & bus.px_ready;
        col_wrap = (bus.px_col == RW'(COLS - 1));
        nxt_col  = col_wrap ? '0 : bus.px_col + RW'(1);
        nxt_row  = col_wrap ? bus.px_row + RW'(1) : bus.px_row;
        nxt_idx  = idx + IW'(1);
        nxt_data = shadow[int'(nxt_idx) * EW +: EW];
        max_cur  = (bus.px_data > run_max) ? bus.px_data : run_max;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            shadow         <= '0;
            idx            <= '0;
            run_max        <= '0;
            bus.fmap_ready <= 1'b1;
            bus.px_data    <= '0;
            bus.px_row     <= '0;
            bus.px_col     <= '0;
            bus.px_last    <= 1'b0;
            bus.px_valid   <= 1'b0;
            bus.frame_max  <= '0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.fmap_valid) begin
                        shadow         <= bus.fmap_in;
                        idx            <= '0;
                        run_max        <= '0;
                        bus.px_data    <= bus.fmap_in[EW-1:0];
                        bus.px_row     <= '0;
                        bus.px_col     <= '0;
                        bus.px_last    <= (N == 1);
                        bus.px_valid   <= 1'b1;
                        bus.fmap_ready <= 1'b0;
                        state          <= STREAM;
                    end
                end
                STREAM: begin
                    if (hs) begin
                        if (bus.px_last) begin
                            bus.frame_max  <= max_cur;
                            bus.frame_done <= 1'b1;
                            bus.px_valid   <= 1'b0;
                            bus.px_last    <= 1'b0;
                            bus.fmap_ready <= 1'b1;
                            state          <= IDLE;
                        end else begin
                            run_max     <= max_cur;
                            idx         <= nxt_idx;
                            bus.px_data <= nxt_data;
                            bus.px_row  <= nxt_row;
                            bus.px_col  <= nxt_col;
                            bus.px_last <= (nxt_row == RW'(ROWS - 1)) &&
                                           (nxt_col == RW'(COLS - 1));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fmap_stream_reader.sv
// Directed bench for fmap_stream_reader (14x14, 4-bit elements).
module tb_fmap_stream_reader;
    localparam int ROWS = 14;
    localparam int COLS = 14;
    localparam int EW   = 4;
    localparam int RW   = 4;
    localparam int N    = ROWS * COLS;

    typedef logic [N*EW-1:0] frame_t;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    fmap_stream_reader_if #(.ROWS(ROWS), .COLS(COLS), .EW(EW), .RW(RW)) bus ();

    fmap_stream_reader #(.ROWS(ROWS), .COLS(COLS), .EW(EW), .RW(RW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic frame_t fill(input logic [3:0] v);
        frame_t f;
        for (int unsigned i = 0; i < N; i++) f[i*EW +: EW] = v;
        return f;
    endfunction

    function automatic frame_t ramp(input bit down);
        frame_t f;
        for (int unsigned i = 0; i < N; i++) f[i*EW +: EW] = down ? 4'(15 - (i % 16)) : 4'(i % 16);
        return f;
    endfunction

    function automatic frame_t rand_frame();
        frame_t f;
        for (int unsigned i = 0; i < N; i++) f[i*EW +: EW] = 4'($urandom_range(0, 15));
        return f;
    endfunction

    // Present a frame while idle; the capture happens on the next rising edge.
    task automatic capture(input frame_t fr, input bit keep_valid);
        chk("cap_fmap_ready", bus.fmap_ready, 1);
        chk("cap_px_valid", bus.px_valid, 0);
        bus.fmap_in    = fr;
        bus.fmap_valid = 1'b1;
        @(posedge clk); #1;
        if (!keep_valid) bus.fmap_valid = 1'b0;
    endtask

    // mode 0: px_ready=1; 1: random px_ready; 2: px_ready=1 but 20 stalls on last.
    // Entered one cycle after capture; returns in the frame_done cycle, or right
    // after element abort_after is accepted when abort_after >= 0.
    task automatic stream(input frame_t fr, input int mode, input bit junk,
                          input logic [3:0] exp_max, input logic [3:0] prev_max,
                          input int abort_after);
        int k     = 0;
        int cyc   = 1;
        int stall = 0;
        bit rdy;
        bit done  = 0;
        while (!done) begin
            if (cyc > 2000) begin
                chk("stream_timeout", k, N);
                bus.px_ready = 1'b0;
                return;
            end
            chk("px_valid", bus.px_valid, 1);
            chk("fmap_ready_busy", bus.fmap_ready, 0);
            chk("frame_done_early", bus.frame_done, 0);
            chk("frame_max_hold", bus.frame_max, prev_max);
            chk("px_data", bus.px_data, fr[k*EW +: EW]);
            chk("px_row", bus.px_row, k / COLS);
            chk("px_col", bus.px_col, k % COLS);
            chk("px_last", bus.px_last, (k == N - 1));
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom_range(0, 1));
                default: rdy = !(k == N - 1 && stall < 20);
            endcase
            if (!rdy) stall++;
            bus.px_ready = rdy;
            if (junk) bus.fmap_in = rand_frame();
            @(posedge clk); #1;
            cyc++;
            if (rdy) begin
                if (k == N - 1) done = 1;
                k++;
                if (abort_after >= 0 && k == abort_after + 1) return;
            end
        end
        bus.px_ready = 1'b0;
        chk("frame_done", bus.frame_done, 1);
        chk("done_px_valid", bus.px_valid, 0);
        chk("done_fmap_ready", bus.fmap_ready, 1);
        chk("frame_max", bus.frame_max, exp_max);
        if (mode == 0) chk("done_cycle", cyc, 197);
        if (mode == 2) chk("done_cycle_stalled", cyc, 217);
    endtask

    // One idle cycle after a frame: pulse must be gone, max must hold.
    task automatic idle_check(input logic [3:0] exp_max);
        @(posedge clk); #1;
        chk("idle_frame_done", bus.frame_done, 0);
        chk("idle_px_valid", bus.px_valid, 0);
        chk("idle_frame_max", bus.frame_max, exp_max);
    endtask

    frame_t fz;

    initial begin
        rst_n          = 1'b0;
        bus.fmap_in    = '0;
        bus.fmap_valid = 1'b0;
        bus.px_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset state, and px_ready while idle does nothing
        chk("rst_fmap_ready", bus.fmap_ready, 1);
        chk("rst_px_valid", bus.px_valid, 0);
        chk("rst_px_data", bus.px_data, 0);
        chk("rst_px_last", bus.px_last, 0);
        chk("rst_frame_max", bus.frame_max, 0);
        chk("rst_frame_done", bus.frame_done, 0);
        bus.px_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.px_ready = 1'b0;
        chk("idle_ready_px_valid", bus.px_valid, 0);
        chk("idle_ready_fmap_ready", bus.fmap_ready, 1);

        // 1: ramp, full throughput
        capture(ramp(0), 0);
        stream(ramp(0), 0, 0, 4'd15, 4'd0, -1);
        idle_check(4'd15);

        // 2: ramp, random px_ready
        capture(ramp(0), 0);
        stream(ramp(0), 1, 0, 4'd15, 4'd15, -1);
        idle_check(4'd15);

        // 3: single 9 at (7,3), then all 2s
        fz = fill(4'd0);
        fz[(7*COLS + 3)*EW +: EW] = 4'd9;
        capture(fz, 0);
        stream(fz, 0, 0, 4'd9, 4'd15, -1);
        idle_check(4'd9);
        capture(fill(4'd2), 0);
        stream(fill(4'd2), 0, 0, 4'd2, 4'd9, -1);
        idle_check(4'd2);

        // 4: fmap_valid held, fmap_in changing; next frame chained off frame_done cycle
        capture(fill(4'd4), 1);
        stream(fill(4'd4), 0, 1, 4'd4, 4'd2, -1);
        bus.fmap_in = ramp(1);
        @(posedge clk); #1;
        bus.fmap_valid = 1'b0;
        stream(ramp(1), 0, 0, 4'd15, 4'd4, -1);
        idle_check(4'd15);

        // 5: reset after element 50 accepted
        capture(ramp(0), 0);
        stream(ramp(0), 0, 0, 4'd15, 4'd15, 50);
        bus.px_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_px_valid", bus.px_valid, 0);
        chk("arst_px_data", bus.px_data, 0);
        chk("arst_px_row", bus.px_row, 0);
        chk("arst_px_col", bus.px_col, 0);
        chk("arst_fmap_ready", bus.fmap_ready, 1);
        chk("arst_frame_max", bus.frame_max, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("arst_frame_done", bus.frame_done, 0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_frame_done", bus.frame_done, 0);
        chk("post_rst_frame_max", bus.frame_max, 0);
        capture(ramp(1), 0);
        stream(ramp(1), 0, 0, 4'd15, 4'd0, -1);
        idle_check(4'd15);

        // 6: stall 20 cycles on the last element
        capture(fill(4'd6), 0);
        stream(fill(4'd6), 2, 0, 4'd6, 4'd15, -1);
        idle_check(4'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
